// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window controller (sobel_window_ctrl).
package sobel_pkg;

  localparam int PIX_W = 12;
  localparam int CH_W  = 4;
  localparam int N_CH  = PIX_W / CH_W;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

  // One vertical slice of the 3x3 window: up, middle, down.
  typedef struct packed {
    pixel_t u;
    pixel_t m;
    pixel_t d;
  } column_t;

  function automatic pixel_t binarise(input pixel_t p, input logic [CH_W-1:0] thresh);
    pixel_t r;
    r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      r[ch*CH_W +: CH_W] = (p[ch*CH_W +: CH_W] >= thresh) ? {CH_W{1'b1}} : {CH_W{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel history: single write port, single registered read port.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int  DEPTH = 640,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  pixel_t        wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output pixel_t        rd_data_o
);

  pixel_t mem_q [DEPTH];
  pixel_t rd_data_q;

  // NOTE: the array and its read register have no reset so they map onto block RAM;
  // stale contents only ever feed border pixels, which are masked.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streaming 3x3 window controller for an external Sobel kernel.
// Optional per-channel binarisation of the result when SOBEL_THRESH_EN is defined.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int              H_ACTIVE    = 640,
  parameter int              V_ACTIVE    = 480,
  parameter logic [CH_W-1:0] EDGE_THRESH = 4'h6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [PIX_W-1:0] win_lu,
  output logic [PIX_W-1:0] win_lm,
  output logic [PIX_W-1:0] win_ld,
  output logic [PIX_W-1:0] win_mu,
  output logic [PIX_W-1:0] win_md,
  output logic [PIX_W-1:0] win_ru,
  output logic [PIX_W-1:0] win_rm,
  output logic [PIX_W-1:0] win_rd,
  input  logic [PIX_W-1:0] edge_in,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [PIX_W-1:0] out_pixel
);

  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = $clog2(V_ACTIVE);
  localparam int FL_W  = $clog2(H_ACTIVE + 3);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [FL_W-1:0]  FL_INJ   = FL_W'(H_ACTIVE);
  localparam logic [FL_W-1:0]  FL_DONE  = FL_W'(H_ACTIVE + 2);

  state_e           state_q;
  logic             in_ready_q;
  logic [COL_W-1:0] col_q, col_d, ccol_q, ccol_d, wr_col;
  logic [ROW_W-1:0] row_q, row_d, crow_q, crow_d;
  logic [FL_W-1:0]  fl_cnt_q;
  column_t          left_q, mid_q, right_q;
  logic             emit_q, emit_border_q, emit_sof_q, emit_eof_q;
  logic             out_valid_q, out_sof_q, out_eof_q;
  pixel_t           out_pixel_q;

  logic   accept, start, pix_acc, inject, shift, emit_now, fill_done, last_pix, centre_border;
  pixel_t shift_pix, lb1_rd, lb2_rd, edge_shaped;

  // Input and centre counters. The centre counter trails the input by H_ACTIVE+1 pixels.
  // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
  always_comb begin
    accept    = in_valid & in_ready_q;
    start     = accept & in_sof;
    pix_acc   = accept & ((state_q != IDLE) | in_sof);
    inject    = (state_q == FLUSH) & (fl_cnt_q <= FL_INJ);
    shift     = pix_acc | inject;
    shift_pix = inject ? '0 : in_pixel;
    wr_col    = start ? '0 : col_q;
    fill_done = (state_q == FILL) & pix_acc & ~in_sof & (row_q == ROW_ONE) & (col_q == '0);
    last_pix  = (state_q == RUN) & pix_acc & ~in_sof & (row_q == ROW_LAST) & (col_q == COL_LAST);
    emit_now  = ((state_q == RUN) & pix_acc & ~in_sof) | inject;

    col_d = col_q;
    row_d = start ? '0 : row_q;
    if (shift) begin
      col_d = (wr_col == COL_LAST) ? '0 : wr_col + 1'b1;
      if ((wr_col == COL_LAST) && (row_d != ROW_LAST)) begin
        row_d = row_d + 1'b1;
      end
    end

    ccol_d = ccol_q;
    crow_d = crow_q;
    if (start) begin
      ccol_d = '0;
      crow_d = '0;
    end else if (emit_now) begin
      if (ccol_q == COL_LAST) begin
        ccol_d = '0;
        if (crow_q != ROW_LAST) begin
          crow_d = crow_q + 1'b1;
        end
      end else begin
        ccol_d = ccol_q + 1'b1;
      end
    end

    centre_border = (ccol_q == '0) | (ccol_q == COL_LAST) | (crow_q == '0) | (crow_q == ROW_LAST);
  end

`ifdef SOBEL_THRESH_EN
  assign edge_shaped = binarise(edge_in, EDGE_THRESH);
`else
  logic unused_thresh;
  assign edge_shaped   = edge_in;
  assign unused_thresh = ^EDGE_THRESH;
`endif

  // Read address runs one column ahead so both older rows are ready on the accepting edge.
  sobel_line_buffer #(.DEPTH(H_ACTIVE)) u_lb_prev (
    .clk       (clk),
    .wr_en_i   (shift),
    .wr_addr_i (wr_col),
    .wr_data_i (shift_pix),
    .rd_addr_i (col_d),
    .rd_data_o (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(H_ACTIVE)) u_lb_prev2 (
    .clk       (clk),
    .wr_en_i   (shift),
    .wr_addr_i (wr_col),
    .wr_data_i (lb1_rd),
    .rd_addr_i (col_d),
    .rd_data_o (lb2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      col_q         <= '0;
      row_q         <= '0;
      ccol_q        <= '0;
      crow_q        <= '0;
      fl_cnt_q      <= '0;
      left_q        <= '0;
      mid_q         <= '0;
      right_q       <= '0;
      emit_q        <= 1'b0;
      emit_border_q <= 1'b0;
      emit_sof_q    <= 1'b0;
      emit_eof_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      out_pixel_q   <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      ccol_q <= ccol_d;
      crow_q <= crow_d;

      if (shift) begin
        left_q  <= mid_q;
        mid_q   <= right_q;
        right_q <= '{u: lb2_rd, m: lb1_rd, d: shift_pix};
      end

      // Capture the centre's flags now; the kernel result is registered one cycle later.
      emit_q <= emit_now;
      if (emit_now) begin
        emit_border_q <= centre_border;
        emit_sof_q    <= (ccol_q == '0) & (crow_q == '0);
        emit_eof_q    <= (ccol_q == COL_LAST) & (crow_q == ROW_LAST);
      end

      out_valid_q <= emit_q;
      out_sof_q   <= emit_q & emit_sof_q;
      out_eof_q   <= emit_q & emit_eof_q;
      if (emit_q) begin
        out_pixel_q <= emit_border_q ? '0 : edge_shaped;
      end

      case (state_q)
        IDLE: begin
          if (start) state_q <= FILL;
        end
        FILL: begin
          if (fill_done) state_q <= RUN;
        end
        RUN: begin
          if (start) begin
            state_q <= FILL;
          end else if (last_pix) begin
            state_q    <= FLUSH;
            in_ready_q <= 1'b0;
            fl_cnt_q   <= '0;
          end
        end
        FLUSH: begin
          fl_cnt_q <= fl_cnt_q + 1'b1;
          if (fl_cnt_q == FL_DONE) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_pixel = out_pixel_q;

  assign win_lu = left_q.u;
  assign win_lm = left_q.m;
  assign win_ld = left_q.d;
  assign win_mu = mid_q.u;
  assign win_md = mid_q.d;
  assign win_ru = right_q.u;
  assign win_rm = right_q.m;
  assign win_rd = right_q.d;

endmodule
